// File: rtl/param_shift_reg.sv
// rtl/param_shift_reg.sv - WIDTH-bit register with parallel load and a one-bit-per-clock shift/rotate engine
// A start in IDLE latches mode/amount; SHIFT moves one bit per edge, DONE gives a one-cycle pulse.
module param_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [1:0]       mode_l;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = q;
    case (mode_l)
      2'b00:   shifted = {q[WIDTH-2:0], serial_in};
      2'b01:   shifted = {serial_in, q[WIDTH-1:1]};
      2'b10:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      default: shifted = {q[0], q[WIDTH-1:1]};
    endcase
  end

  // mode_l[0] set means a rightward move, so the bit leaving next is q[0]
  assign serial_out = mode_l[0] ? q[0] : q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= RESET_VAL;
      mode_l <= 2'b00;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            q <= load_data;
          end else if (start) begin
            mode_l <= mode;
            if (amount == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cnt   <= amount;
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q   <= shifted;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_shift_reg.sv
// tb/tb_param_shift_reg.sv - randomized and directed checks of param_shift_reg against a count-based model
module tb_param_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] amount = '0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;

  param_shift_reg #(.WIDTH(W), .CNT_W(CW), .RESET_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data),
    .start(start), .mode(mode), .amount(amount), .serial_in(serial_in),
    .q(q), .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference state: register value, shifts still owed, latched mode, pulse
  int         m_q;
  int         m_left;
  logic [1:0] m_mode;
  logic       m_done;
  int         done_pulses;

  function automatic int shift_once(int v, logic [1:0] md, int s);
    int full = 1 << W;
    int msb  = v / (1 << (W - 1));
    int lsb  = v % 2;
    case (md)
      2'b00:   return (v * 2 + s) % full;
      2'b01:   return v / 2 + s * (1 << (W - 1));
      2'b10:   return (v * 2 + msb) % full;
      default: return v / 2 + lsb * (1 << (W - 1));
    endcase
  endfunction

  task automatic model_reset();
    m_q = 0; m_left = 0; m_mode = 2'b00; m_done = 1'b0;
  endtask

  task automatic model_step();
    logic nd = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_left > 0) begin
      m_q = shift_once(m_q, m_mode, int'(serial_in));
      m_left--;
      if (m_left == 0) nd = 1'b1;
    end else if (m_done) begin
      nd = 1'b0;
    end else if (load) begin
      m_q = int'(load_data);
    end else if (start) begin
      m_mode = mode;
      if (amount == 0) nd = 1'b1;
      else m_left = int'(amount);
    end
    m_done = nd;
  endtask

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int exp_so = m_mode[0] ? (m_q % 2) : (m_q / (1 << (W - 1)));
    check("q", int'(q), m_q);
    check("busy", int'(busy), int'(m_left > 0));
    check("done", int'(done), int'(m_done));
    check("serial_out", int'(serial_out), exp_so);
    if (done) done_pulses++;
  endtask

  // inputs are set at the negedge before calling; compare at the following negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0;
  endtask

  task automatic do_load(logic [W-1:0] v);
    load = 1'b1; load_data = v; start = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic do_start(logic [1:0] md, logic [CW-1:0] n);
    start = 1'b1; mode = md; amount = n; load = 1'b0;
    tick();
    idle_inputs();
  endtask

  initial begin
    model_reset();
    done_pulses = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    check("reset_q_literal", int'(q), 0);
    check("reset_so_literal", int'(serial_out), 0);

    // rotate-left 0xA5 by 3
    do_load(8'hA5);
    do_start(2'b10, 4'd3);
    check("rol_busy_e0", int'(busy), 1);
    tick(); check("rol_q1", int'(q), 8'h4B);
    tick(); check("rol_q2", int'(q), 8'h96);
    tick(); check("rol_q3", int'(q), 8'h2D);
    check("rol_done", int'(done), 1);
    check("rol_busy_in_done", int'(busy), 0);
    tick(); check("rol_done_gone", int'(done), 0);

    // logical right of 0x81 with serial_in=1
    do_load(8'h81);
    serial_in = 1'b1;
    do_start(2'b01, 4'd2);
    check("shr_so_before1", int'(serial_out), 1);
    tick(); check("shr_q1", int'(q), 8'hC0);
    check("shr_so_before2", int'(serial_out), 0);
    tick(); check("shr_q2", int'(q), 8'hE0);
    tick();

    // rotate-right 0x01 by 9 wraps to a single position
    do_load(8'h01);
    done_pulses = 0;
    do_start(2'b11, 4'd9);
    for (int i = 0; i < 9; i++) tick();
    check("ror9_q", int'(q), 8'h80);
    tick(); tick();
    check("ror9_pulses", done_pulses, 1);

    // amount 0: straight to done, no busy
    do_load(8'h3C);
    do_start(2'b00, 4'd0);
    check("amt0_done", int'(done), 1);
    check("amt0_busy", int'(busy), 0);
    check("amt0_q", int'(q), 8'h3C);
    tick(); check("amt0_done_once", int'(done), 0);

    // load beats simultaneous start
    load = 1'b1; load_data = 8'h55; start = 1'b1; mode = 2'b00; amount = 4'd4;
    tick();
    idle_inputs();
    check("ldst_q", int'(q), 8'h55);
    check("ldst_busy", int'(busy), 0);
    tick(); check("ldst_done", int'(done), 0);

    // asynchronous reset three shifts into an 8-shift run
    do_load(8'hFF);
    serial_in = 1'b0;
    do_start(2'b00, 4'd8);
    tick(); tick(); tick();
    check("pre_rst_q", int'(q), 8'hF8);
    done_pulses = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_q", int'(q), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_so", int'(serial_out), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("arst_no_pulse", done_pulses, 0);

    // inputs toggled during SHIFT are ignored
    do_load(8'h5A);
    do_start(2'b10, 4'd5);
    for (int i = 0; i < 5; i++) begin
      load = 1'($urandom); start = 1'($urandom); load_data = 8'($urandom);
      mode = 2'($urandom); amount = 4'($urandom);
      tick();
    end
    idle_inputs();
    check("ignore_q", int'(q), 8'h4B);
    check("ignore_done", int'(done), 1);
    tick();

    // randomized traffic compared every cycle
    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(0, 7) == 0);
      start     = ($urandom_range(0, 3) == 0);
      load_data = 8'($urandom);
      mode      = 2'($urandom);
      amount    = 4'($urandom);
      serial_in = 1'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
